// File: rtl/rx_seq_pkg.sv
// Shared constants, column classification type and small helpers for the
// XGMII Sequence ordered-set detector.
package rx_seq_pkg;

  localparam logic [7:0] SEQ_CHAR = 8'h9C;
  localparam logic [7:0] LF_CODE  = 8'h01;
  localparam logic [7:0] RF_CODE  = 8'h02;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    LOCAL   = 2'd1,
    REMOTE  = 2'd2,
    UNKNOWN = 2'd3
  } col_class_t;

  // A column that carries a Local or Remote Fault ordered set.
  function automatic logic is_fault(input col_class_t cls);
    return (cls == LOCAL) || (cls == REMOTE);
  endfunction

  // Number of the two columns (0, 1 or 2) that match the given class.
  function automatic logic [1:0] col_count(input col_class_t lo,
                                           input col_class_t hi,
                                           input col_class_t kind);
    return {1'b0, (lo == kind)} + {1'b0, (hi == kind)};
  endfunction

endpackage

// File: rtl/rx_seq_col_decode.sv
// Combinational classifier for one 4-lane XGMII column.
// Lane 0 of the column is col_data[7:0] with control flag col_ctrl[0].
module rx_seq_col_decode
  import rx_seq_pkg::*;
(
  input  logic [31:0] col_data,
  input  logic [3:0]  col_ctrl,
  output col_class_t  col_class
);

  logic is_seq_s;

  // A Sequence column: control 9C in the first lane, data zeros in the next two.
  always_comb begin
    is_seq_s = 1'b0;
    if ((col_ctrl == 4'b0001) &&
        (col_data[7:0] == SEQ_CHAR) &&
        (col_data[15:8] == 8'h00) &&
        (col_data[23:16] == 8'h00)) begin
      is_seq_s = 1'b1;
    end else begin
      is_seq_s = 1'b0;
    end
  end

  // Classify a Sequence column by its last lane; anything else is NONE.
  always_comb begin
    col_class = NONE;
    if (is_seq_s) begin
      case (col_data[31:24])
        LF_CODE: col_class = LOCAL;
        RF_CODE: col_class = REMOTE;
        default: col_class = UNKNOWN;
      endcase
    end else begin
      col_class = NONE;
    end
  end

endmodule

// File: rtl/rx_seq_detect.sv
// XGMII Sequence ordered-set detector: input register stage, two column
// classifiers, lane-4-wins priority merge into registered fault indications,
// saturating statistics and a sticky fault flag.
module rx_seq_detect
  import rx_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             rxclk,
  input  logic             reset,
  input  logic [63:0]      rxd_in,
  input  logic [7:0]       rxc_in,
  input  logic             cfg_enable,
  input  logic             stat_clear,
  output logic             local_fault,
  output logic             remote_fault,
  output logic             seq_unknown,
  output logic [CNT_W-1:0] lf_count,
  output logic [CNT_W-1:0] rf_count,
  output logic [CNT_W-1:0] unk_count,
  output logic             sticky_fault
);

  logic [63:0]      rxd_r;
  logic [7:0]       rxc_r;
  col_class_t       lo_class_s;
  col_class_t       hi_class_s;
  col_class_t       fault_class_s;
  logic             local_fault_s;
  logic             remote_fault_s;
  logic             seq_unknown_s;
  logic             sticky_fault_s;
  logic [CNT_W-1:0] lf_count_s;
  logic [CNT_W-1:0] rf_count_s;
  logic [CNT_W-1:0] unk_count_s;
  logic             local_fault_r;
  logic             remote_fault_r;
  logic             seq_unknown_r;
  logic             sticky_fault_r;
  logic [CNT_W-1:0] lf_count_r;
  logic [CNT_W-1:0] rf_count_r;
  logic [CNT_W-1:0] unk_count_r;

  // Add 0..2 to a counter, sticking at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  // Stage 1: capture the raw XGMII column pair; runs regardless of cfg_enable.
  always_ff @(posedge rxclk) begin
    if (reset) begin
      rxd_r <= 64'h0;
      rxc_r <= 8'h00;
    end else begin
      rxd_r <= rxd_in;
      rxc_r <= rxc_in;
    end
  end

  rx_seq_col_decode u_col_lo (
    .col_data  (rxd_r[31:0]),
    .col_ctrl  (rxc_r[3:0]),
    .col_class (lo_class_s)
  );

  rx_seq_col_decode u_col_hi (
    .col_data  (rxd_r[63:32]),
    .col_ctrl  (rxc_r[7:4]),
    .col_class (hi_class_s)
  );

  // Priority merge: the lane-4 column is later in time, so it wins a conflict.
  always_comb begin
    fault_class_s = NONE;
    if (is_fault(hi_class_s)) begin
      fault_class_s = hi_class_s;
    end else if (is_fault(lo_class_s)) begin
      fault_class_s = lo_class_s;
    end else begin
      fault_class_s = NONE;
    end
  end

  // Next values of the indications, counters and sticky flag.
  always_comb begin
    local_fault_s  = cfg_enable && (fault_class_s == LOCAL);
    remote_fault_s = cfg_enable && (fault_class_s == REMOTE);
    seq_unknown_s  = cfg_enable && ((lo_class_s == UNKNOWN) || (hi_class_s == UNKNOWN));
    lf_count_s     = lf_count_r;
    rf_count_s     = rf_count_r;
    unk_count_s    = unk_count_r;
    sticky_fault_s = sticky_fault_r;
    if (stat_clear) begin
      // Clear beats any event decoded in the same cycle.
      lf_count_s     = {CNT_W{1'b0}};
      rf_count_s     = {CNT_W{1'b0}};
      unk_count_s    = {CNT_W{1'b0}};
      sticky_fault_s = 1'b0;
    end else if (cfg_enable) begin
      // Both columns count, even when only one drives the indication.
      lf_count_s     = sat_add(lf_count_r,  col_count(lo_class_s, hi_class_s, LOCAL));
      rf_count_s     = sat_add(rf_count_r,  col_count(lo_class_s, hi_class_s, REMOTE));
      unk_count_s    = sat_add(unk_count_r, col_count(lo_class_s, hi_class_s, UNKNOWN));
      sticky_fault_s = sticky_fault_r | is_fault(lo_class_s) | is_fault(hi_class_s);
    end else begin
      lf_count_s     = lf_count_r;
      rf_count_s     = rf_count_r;
      unk_count_s    = unk_count_r;
      sticky_fault_s = sticky_fault_r;
    end
  end

  // Stage 2: register indications and statistics.
  always_ff @(posedge rxclk) begin
    if (reset) begin
      local_fault_r  <= 1'b0;
      remote_fault_r <= 1'b0;
      seq_unknown_r  <= 1'b0;
      sticky_fault_r <= 1'b0;
      lf_count_r     <= {CNT_W{1'b0}};
      rf_count_r     <= {CNT_W{1'b0}};
      unk_count_r    <= {CNT_W{1'b0}};
    end else begin
      local_fault_r  <= local_fault_s;
      remote_fault_r <= remote_fault_s;
      seq_unknown_r  <= seq_unknown_s;
      sticky_fault_r <= sticky_fault_s;
      lf_count_r     <= lf_count_s;
      rf_count_r     <= rf_count_s;
      unk_count_r    <= unk_count_s;
    end
  end

  assign local_fault  = local_fault_r;
  assign remote_fault = remote_fault_r;
  assign seq_unknown  = seq_unknown_r;
  assign sticky_fault = sticky_fault_r;
  assign lf_count     = lf_count_r;
  assign rf_count     = rf_count_r;
  assign unk_count    = unk_count_r;

endmodule

// File: tb/tb_rx_seq_detect.sv
// Self-checking bench for rx_seq_detect: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// behavioural model of the detector.
module tb_rx_seq_detect;

  localparam logic [31:0] COL_LF   = 32'h0100_009C;
  localparam logic [31:0] COL_RF   = 32'h0200_009C;
  localparam logic [31:0] COL_UNK5 = 32'h0500_009C;
  localparam logic [31:0] COL_BAD  = 32'h0100_019C;
  localparam logic [31:0] COL_IDLE = 32'h0707_0707;
  localparam int          SAT      = 65535;

  logic        rxclk;
  logic        reset;
  logic [63:0] rxd_in;
  logic [7:0]  rxc_in;
  logic        cfg_enable;
  logic        stat_clear;
  logic        local_fault;
  logic        remote_fault;
  logic        seq_unknown;
  logic [15:0] lf_count;
  logic [15:0] rf_count;
  logic [15:0] unk_count;
  logic        sticky_fault;

  rx_seq_detect #(.CNT_W(16)) dut (
    .rxclk        (rxclk),
    .reset        (reset),
    .rxd_in       (rxd_in),
    .rxc_in       (rxc_in),
    .cfg_enable   (cfg_enable),
    .stat_clear   (stat_clear),
    .local_fault  (local_fault),
    .remote_fault (remote_fault),
    .seq_unknown  (seq_unknown),
    .lf_count     (lf_count),
    .rf_count     (rf_count),
    .unk_count    (unk_count),
    .sticky_fault (sticky_fault)
  );

  initial rxclk = 1'b0;
  always #5 rxclk = ~rxclk;

  int n_vec = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  // Model state: the column pair seen at the previous edge, and expected outputs.
  logic [63:0] m_d1 = 64'h0;
  logic [7:0]  m_c1 = 8'h00;
  bit m_lf, m_rf, m_unk, m_sticky;
  int m_lfc, m_rfc, m_unkc;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // 0 = no indication, 1 = local, 2 = remote, 3 = unknown sequence.
  function automatic int classify(input logic [31:0] d, input logic [3:0] c);
    if (c == 4'b0001 && d[7:0] == 8'h9C && d[23:8] == 16'h0000) begin
      if (d[31:24] == 8'h01) return 1;
      if (d[31:24] == 8'h02) return 2;
      return 3;
    end
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Advance the model by one edge using the inputs present at that edge.
  task automatic model_step();
    int lo, hi, win;
    if (reset) begin
      m_lf = 0; m_rf = 0; m_unk = 0; m_sticky = 0;
      m_lfc = 0; m_rfc = 0; m_unkc = 0;
      m_d1 = 64'h0; m_c1 = 8'h00;
    end else begin
      lo = classify(m_d1[31:0], m_c1[3:0]);
      hi = classify(m_d1[63:32], m_c1[7:4]);
      win = (hi == 1 || hi == 2) ? hi : ((lo == 1 || lo == 2) ? lo : 0);
      m_lf  = cfg_enable && (win == 1);
      m_rf  = cfg_enable && (win == 2);
      m_unk = cfg_enable && (lo == 3 || hi == 3);
      if (stat_clear) begin
        m_lfc = 0; m_rfc = 0; m_unkc = 0; m_sticky = 0;
      end else if (cfg_enable) begin
        m_lfc  = sat(m_lfc  + int'(lo == 1) + int'(hi == 1));
        m_rfc  = sat(m_rfc  + int'(lo == 2) + int'(hi == 2));
        m_unkc = sat(m_unkc + int'(lo == 3) + int'(hi == 3));
        if (win != 0) m_sticky = 1;
      end
      m_d1 = rxd_in;
      m_c1 = rxc_in;
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge rxclk) begin
    if (chk_en) begin
      cmp("local_fault",  {31'b0, local_fault},  {31'b0, m_lf});
      cmp("remote_fault", {31'b0, remote_fault}, {31'b0, m_rf});
      cmp("seq_unknown",  {31'b0, seq_unknown},  {31'b0, m_unk});
      cmp("sticky_fault", {31'b0, sticky_fault}, {31'b0, m_sticky});
      cmp("lf_count",     {16'b0, lf_count},     m_lfc);
      cmp("rf_count",     {16'b0, rf_count},     m_rfc);
      cmp("unk_count",    {16'b0, unk_count},    m_unkc);
    end
  end

  task automatic drive(input logic [63:0] d, input logic [7:0] c,
                       input logic rst, input logic en, input logic clr);
    rxd_in = d; rxc_in = c; reset = rst; cfg_enable = en; stat_clear = clr;
    @(posedge rxclk);
    model_step();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive({COL_IDLE, COL_IDLE}, 8'hFF, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic clear_stats();
    drive({COL_IDLE, COL_IDLE}, 8'hFF, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic rand_col(output logic [31:0] d, output logic [3:0] c);
    logic [31:0] t;
    case ($urandom_range(0, 7))
      0, 6:    begin d = COL_LF; c = 4'h1; end
      1, 7:    begin d = COL_RF; c = 4'h1; end
      2:       begin d = {8'($urandom_range(3, 255)), 24'h00009C}; c = 4'h1; end
      3:       begin d = COL_IDLE; c = 4'hF; end
      4: begin
        t = ($urandom_range(0, 1) == 0) ? COL_LF : COL_RF;
        c = 4'h1;
        case ($urandom_range(0, 3))
          0:       c = 4'h1 | (4'h2 << $urandom_range(0, 2));
          1:       t[15:8] = 8'($urandom_range(1, 255));
          2:       t[7:0] = 8'h9D;
          default: c = 4'h0;
        endcase
        d = t;
      end
      default: begin d = $urandom; c = 4'($urandom); end
    endcase
  endtask

  initial begin
    logic [31:0] dl, dh;
    logic [3:0]  cl, ch;
    rxd_in = 64'h0; rxc_in = 8'h00; reset = 1'b1; cfg_enable = 1'b1; stat_clear = 1'b0;

    // Reset state.
    for (int i = 0; i < 3; i++) drive({COL_IDLE, COL_IDLE}, 8'hFF, 1'b1, 1'b1, 1'b0);
    cmp("reset_local", {31'b0, local_fault}, 32'd0);
    cmp("reset_lfcnt", {16'b0, lf_count}, 32'd0);
    cmp("reset_sticky", {31'b0, sticky_fault}, 32'd0);
    idle(2);

    // 1: LF in lane 0 held 4 cycles, indication 2 cycles later, then a gap.
    clear_stats();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive({COL_IDLE, COL_LF}, 8'hF1, 1'b0, 1'b1, 1'b0);
      else       idle(1);
      if (i >= 1 && i <= 4) cmp("t1_local_on", {31'b0, local_fault}, 32'd1);
      if (i == 5)           cmp("t1_local_gap", {31'b0, local_fault}, 32'd0);
    end
    idle(1);
    cmp("t1_lf_count", {16'b0, lf_count}, 32'd4);
    cmp("t1_sticky", {31'b0, sticky_fault}, 32'd1);

    // 2: RF in lanes 0-3, LF in lanes 4-7: lane-4 column wins, both counted.
    clear_stats();
    drive({COL_LF, COL_RF}, 8'h11, 1'b0, 1'b1, 1'b0);
    idle(1);
    cmp("t2_local", {31'b0, local_fault}, 32'd1);
    cmp("t2_remote", {31'b0, remote_fault}, 32'd0);
    idle(1);
    cmp("t2_lf_count", {16'b0, lf_count}, 32'd1);
    cmp("t2_rf_count", {16'b0, rf_count}, 32'd1);

    // 3: unknown code in lane 4, then a near-miss in lane 0.
    clear_stats();
    drive({COL_UNK5, COL_IDLE}, 8'h1F, 1'b0, 1'b1, 1'b0);
    idle(1);
    cmp("t3_unknown", {31'b0, seq_unknown}, 32'd1);
    cmp("t3_unk_nofault", {30'b0, local_fault, remote_fault}, 32'd0);
    idle(1);
    cmp("t3_unk_count", {16'b0, unk_count}, 32'd1);
    drive({COL_IDLE, COL_BAD}, 8'hF1, 1'b0, 1'b1, 1'b0);
    idle(1);
    cmp("t3_badseq", {29'b0, local_fault, remote_fault, seq_unknown}, 32'd0);

    // 4: fill lf_count to FFFE with +2 per cycle, then saturate.
    clear_stats();
    for (int i = 0; i < 32767; i++) drive({COL_LF, COL_LF}, 8'h11, 1'b0, 1'b1, 1'b0);
    idle(2);
    cmp("t4_lf_fffe", {16'b0, lf_count}, 32'h0000_FFFE);
    drive({COL_LF, COL_LF}, 8'h11, 1'b0, 1'b1, 1'b0);
    idle(2);
    cmp("t4_lf_ffff", {16'b0, lf_count}, 32'h0000_FFFF);
    for (int i = 0; i < 3; i++) drive({COL_LF, COL_LF}, 8'h11, 1'b0, 1'b1, 1'b0);
    idle(2);
    cmp("t4_lf_hold", {16'b0, lf_count}, 32'h0000_FFFF);

    // 5: clear coinciding with an RF decode; then disabled LF stream and re-enable.
    drive({COL_IDLE, COL_RF}, 8'hF1, 1'b0, 1'b1, 1'b0);
    drive({COL_IDLE, COL_IDLE}, 8'hFF, 1'b0, 1'b1, 1'b1);
    cmp("t5_remote_pulse", {31'b0, remote_fault}, 32'd1);
    cmp("t5_rf_cleared", {16'b0, rf_count}, 32'd0);
    cmp("t5_lf_cleared", {16'b0, lf_count}, 32'd0);
    cmp("t5_sticky_cleared", {31'b0, sticky_fault}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive({COL_IDLE, COL_LF}, 8'hF1, 1'b0, 1'b0, 1'b0);
      if (i >= 1) cmp("t5_disabled", {31'b0, local_fault}, 32'd0);
    end
    drive({COL_IDLE, COL_IDLE}, 8'hFF, 1'b0, 1'b1, 1'b0);
    cmp("t5_reenable", {31'b0, local_fault}, 32'd1);
    cmp("t5_frozen_cnt", {16'b0, lf_count}, 32'd1);
    idle(2);

    // 6: reset in the middle of a continuous LF stream.
    for (int i = 0; i < 4; i++) drive({COL_IDLE, COL_LF}, 8'hF1, 1'b0, 1'b1, 1'b0);
    drive({COL_IDLE, COL_LF}, 8'hF1, 1'b1, 1'b1, 1'b0);
    cmp("t6_reset_local", {31'b0, local_fault}, 32'd0);
    cmp("t6_reset_cnt", {16'b0, lf_count}, 32'd0);
    drive({COL_IDLE, COL_LF}, 8'hF1, 1'b0, 1'b1, 1'b0);
    cmp("t6_release1", {31'b0, local_fault}, 32'd0);
    drive({COL_IDLE, COL_LF}, 8'hF1, 1'b0, 1'b1, 1'b0);
    cmp("t6_release2", {31'b0, local_fault}, 32'd1);

    // Randomized traffic with occasional reset, clear and disable.
    for (int i = 0; i < 3000; i++) begin
      logic r, e, k;
      rand_col(dl, cl);
      rand_col(dh, ch);
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 19) != 0);
      k = e && ($urandom_range(0, 49) == 0);
      drive({dh, dl}, {ch, cl}, r, e, k);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
